fp_add: RTL and testbench

- Multi-cycle IEEE-754 single-precision adder/subtractor. It is the sibling FPU stage to fp_mult and consumes its product C directly, for example in an accumulate step.
- It uses the same start/ready handshake as fp_mult, so the sequencer drives both identically.
- One operation is in flight at a time. Alignment and normalisation shift one bit per cycle.

---
 rtl/fp_add.sv | 200 ++++++++++++++++++++
 tb/tb_fp_add.sv | 134 +++++++++++++
 2 files changed

// File: rtl/fp_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp_add : multi-cycle IEEE-754 single-precision adder/subtractor           |
// |          (start/ready handshake, bit-serial alignment and normalisation)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp_add #(
    parameter logic SUB_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        sub,
    input  logic        start,
    output logic [31:0] C,
    output logic        ready
);

    localparam logic [31:0] c_QNAN = 32'h7FC00000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNPACK = 3'd1,
        S_ALIGN  = 3'd2,
        S_ADDSUB = 3'd3,
        S_NORM   = 3'd4,
        S_ROUND  = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t      state_q;
    logic [31:0] a_q, b_q, res_q, C_q;
    logic        ready_q;
    logic        sx_q, sy_q;
    logic [8:0]  ex_q;
    logic [7:0]  ey_q;
    logic [26:0] mx_q, my_q;
    logic [27:0] sum_q;

    // Unpacked operand fields; b_q already carries the effective sign
    logic [7:0]  w_ea, w_eb;
    logic [22:0] w_ma, w_mb;
    logic        w_sa, w_sb;
    logic        w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b, w_a_ge_b;
    logic [7:0]  w_diff;
    logic [27:0] w_sum;
    logic [24:0] w_rnd;
    logic [23:0] w_mant_d;
    logic [8:0]  w_exp_d;
    logic [31:0] w_round_res;

    always_comb begin
        w_sa     = a_q[31];
        w_sb     = b_q[31];
        w_ea     = a_q[30:23];
        w_eb     = b_q[30:23];
        w_ma     = a_q[22:0];
        w_mb     = b_q[22:0];
        w_nan_a  = (w_ea == 8'hFF) && (w_ma != 23'd0);
        w_nan_b  = (w_eb == 8'hFF) && (w_mb != 23'd0);
        w_inf_a  = (w_ea == 8'hFF) && (w_ma == 23'd0);
        w_inf_b  = (w_eb == 8'hFF) && (w_mb == 23'd0);
        w_zero_a = (w_ea == 8'd0);
        w_zero_b = (w_eb == 8'd0);
        w_a_ge_b = (a_q[30:0] >= b_q[30:0]);
    end

    always_comb begin
        w_diff = ex_q[7:0] - ey_q;
        w_sum  = (sx_q != sy_q) ? ({1'b0, mx_q} - {1'b0, my_q})
                                : ({1'b0, mx_q} + {1'b0, my_q});
    end

    // Round to nearest even on sum_q[26:3] with guard/round/sticky below it
    always_comb begin
        w_rnd    = {1'b0, sum_q[26:3]}
                 + {24'd0, sum_q[2] & (sum_q[1] | sum_q[0] | sum_q[3])};
        w_mant_d = w_rnd[24] ? w_rnd[24:1] : w_rnd[23:0];
        w_exp_d  = ex_q + {8'd0, w_rnd[24]};
        if (w_exp_d >= 9'd255) begin
            w_round_res = {sx_q, 8'hFF, 23'd0};
        end else begin
            w_round_res = {sx_q, w_exp_d[7:0], w_mant_d[22:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            C_q     <= 32'd0;
            ready_q <= 1'b1;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            res_q   <= 32'd0;
            sx_q    <= 1'b0;
            sy_q    <= 1'b0;
            ex_q    <= 9'd0;
            ey_q    <= 8'd0;
            mx_q    <= 27'd0;
            my_q    <= 27'd0;
            sum_q   <= 28'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= {B[31] ^ (sub & SUB_EN), B[30:0]};
                        ready_q <= 1'b0;
                        state_q <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    state_q <= S_DONE;
                    if (w_nan_a || w_nan_b || (w_inf_a && w_inf_b && (w_sa != w_sb))) begin
                        res_q <= c_QNAN;
                    end else if (w_inf_a) begin
                        res_q <= a_q;
                    end else if (w_inf_b) begin
                        res_q <= b_q;
                    end else if (w_zero_a && w_zero_b) begin
                        res_q <= {w_sa & w_sb, 31'd0};
                    end else if (w_zero_a) begin
                        res_q <= b_q;
                    end else if (w_zero_b) begin
                        res_q <= a_q;
                    end else begin
                        state_q <= S_ALIGN;
                        if (w_a_ge_b) begin
                            sx_q <= w_sa;
                            ex_q <= {1'b0, w_ea};
                            mx_q <= {1'b1, w_ma, 3'b000};
                            sy_q <= w_sb;
                            ey_q <= w_eb;
                            my_q <= {1'b1, w_mb, 3'b000};
                        end else begin
                            sx_q <= w_sb;
                            ex_q <= {1'b0, w_eb};
                            mx_q <= {1'b1, w_mb, 3'b000};
                            sy_q <= w_sa;
                            ey_q <= w_ea;
                            my_q <= {1'b1, w_ma, 3'b000};
                        end
                    end
                end
                S_ALIGN: begin
                    if (w_diff == 8'd0) begin
                        state_q <= S_ADDSUB;
                    end else if (w_diff > 8'd26) begin
                        my_q    <= 27'd1;
                        ey_q    <= ex_q[7:0];
                        state_q <= S_ADDSUB;
                    end else begin
                        my_q <= {1'b0, my_q[26:2], my_q[1] | my_q[0]};
                        ey_q <= ey_q + 8'd1;
                    end
                end
                S_ADDSUB: begin
                    sum_q   <= w_sum;
                    state_q <= S_NORM;
                end
                S_NORM: begin
                    if (sum_q == 28'd0) begin
                        res_q   <= 32'd0;
                        state_q <= S_DONE;
                    end else if (sum_q[27]) begin
                        sum_q <= {1'b0, sum_q[27:2], sum_q[1] | sum_q[0]};
                        ex_q  <= ex_q + 9'd1;
                    end else if (sum_q[26]) begin
                        state_q <= S_ROUND;
                    end else if (ex_q <= 9'd1) begin
                        // Further left shift would underflow into the denormal range
                        res_q   <= {sx_q, 31'd0};
                        state_q <= S_DONE;
                    end else begin
                        sum_q <= {sum_q[26:0], 1'b0};
                        ex_q  <= ex_q - 9'd1;
                    end
                end
                S_ROUND: begin
                    res_q   <= w_round_res;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    C_q     <= res_q;
                    ready_q <= 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign C     = C_q;
    assign ready = ready_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp_add : directed scoreboard testbench for fp_add                      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp_add;

    logic        clk;
    logic        rst;
    logic [31:0] A, B;
    logic        sub;
    logic        start;
    logic [31:0] C;
    logic        ready;

    int checks;
    int passes;
    logic [31:0] exp_q[$];

    fp_add #(.SUB_EN(1'b1)) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .B     (B),
        .sub   (sub),
        .start (start),
        .C     (C),
        .ready (ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got %08h, expected %08h", name, act, req);
    endtask

    // Monitor: every rising edge of ready delivers one result
    logic prev_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (ready === 1'b1 && prev_ready === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got %08h, expected none", C);
            end else begin
                check("result", C, exp_q.pop_front());
            end
        end
        prev_ready = ready;
    end

    task automatic wait_ready();
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (ready !== 1'b1) begin
            checks++;
            $display("FAIL ready_timeout: got %b, expected 1", ready);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] expv);
        wait_ready();
        @(negedge clk);
        A = a; B = b; sub = s; start = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        start = 1'b0;
        check("ready_fall", {31'd0, ready}, 32'd0);
    endtask

    initial begin
        checks = 0; passes = 0;
        rst = 1'b1; start = 1'b0; A = '0; B = '0; sub = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_C", C, 32'h0);

        issue(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000);
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("C_hold", C, 32'h40000000);
        end

        issue(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000);
        issue(32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000);
        issue(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000);
        issue(32'h3F800000, 32'h33800001, 1'b0, 32'h3F800001);
        issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000);
        issue(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000);
        issue(32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000);
        issue(32'h00000001, 32'h80000000, 1'b0, 32'h00000000);
        issue(32'h4B800000, 32'h3F800000, 1'b0, 32'h4B800000);
        issue(32'h4F000000, 32'h3F800000, 1'b0, 32'h4F000000);
        issue(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000);

        // Reset while aligning: the monitor sees ready rise with C cleared
        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h00000000);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_C", C, 32'h0);

        // A start pulse while busy must be ignored
        issue(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000);
        @(negedge clk);
        A = 32'h3F800000; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_ready();

        for (int n = 0; n < 100 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
